gate_chain_pipe: RTL and testbench
==================================

GATE_CHAIN_PIPE -- requirements
Module: gate_chain_pipe

Interface
REQ-001 Parameter N, default 4: number of chain inputs, legal range 2..16.
REQ-002 Parameter CW, default 8: width of the completed-result counter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_data  input  N  chain operands; bit0=a, bit1=b, bit k = (k+1)th operand.
REQ-007 mode  input  2  gate select: 00 NOR, 01 NAND, 10 XOR, 11 XNOR.
REQ-008 in_valid  input  1  in_data/mode valid this cycle.
REQ-009 in_ready  output  1  block can accept an operand set this cycle.
REQ-010 taps  output  N-1  chain intermediates; taps[0] is the first stage, taps[N-2] is the final result.
REQ-011 result  output  1  equals taps[N-2].
REQ-012 out_valid  output  1  taps/result hold a completed chain.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 done_cnt  output  CW  count of completed output transfers.

Function
REQ-015 Gate f(x,y) per mode: NOR ~(x|y), NAND ~(x&y), XOR x^y, XNOR ~(x^y).
REQ-016 Chain: taps[0]=f(in_data[0],in_data[1]); taps[k]=f(in_data[k+1],taps[k-1]) for k=1..N-2.
REQ-017 Pipeline of N-1 register stages; stage s (1..N-1) computes taps[s-1] and carries valid, mode, unconsumed operands and earlier taps forward.
REQ-018 mode SHALL be captured with in_data at acceptance; a later mode change does not affect in-flight sets.
REQ-019 stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
REQ-020 Accept occurs on a rising edge with in_valid & in_ready.
REQ-021 When not stalled, every stage advances each edge, including invalid (bubble) stages; no bubble collapsing.
REQ-022 When stalled, all stage registers, including the output, hold their values.
REQ-023 Latency: a set accepted on edge t SHALL present out_valid=1 after edge t+N-2, i.e. N-1 edges counting the accept edge, absent stalls.
REQ-024 Throughput: one set per cycle with out_ready held at 1.
REQ-025 Transfer occurs when out_valid & out_ready; done_cnt increments by 1 on each transfer and wraps from 2^CW-1 to 0.
REQ-026 Simultaneous transfer and accept SHALL both complete in the same edge.
REQ-027 taps/result when out_valid=0 are don't-care for checking but SHALL NOT be X after reset.
REQ-028 Ordering: results emerge in acceptance order; none are dropped or duplicated.

Reset
REQ-029 When rst=1, all stage valids, taps, carried operands, mode regs and done_cnt SHALL be 0 immediately, without waiting for clk.
REQ-030 Outputs during and after reset: out_valid=0, taps=0, result=0, done_cnt=0, in_ready=1.
REQ-031 Reset mid-operation discards all in-flight sets; the first accept after rst falls behaves per REQ-023.

Verification
REQ-032 N=4, NOR, in_data=4'b0000, out_ready=1 -> after 3 edges out_valid=1, taps=3'b101, result=1.
REQ-033 N=4, NOR, in_data=4'b0001 -> taps=3'b010; NAND, 4'b1111 -> taps=3'b010, result=0.
REQ-034 N=4, back-to-back sets on 4 consecutive cycles with mode switched each cycle -> 4 consecutive out_valid cycles, each matching the golden chain of its own captured mode.
REQ-035 Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, taps stable; on release, no loss or duplication, and done_cnt +1 per transfer.
REQ-036 Assert rst asynchronously between edges with 2 sets in flight -> outputs zero immediately; after release, no stale out_valid.
REQ-037 CW=2, 5 transfers -> done_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/gate_chain_pipe.sv
// Pipelined chain of 2-input gates with valid/ready handshake on both sides.
// Stage s registers chain tap s-1 and carries the operands, mode and earlier taps it still needs.
module gate_chain_pipe #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-2:0]  taps,
  output logic          result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] done_cnt
);

  localparam int S = N - 1;

  logic          w_stall;
  logic          w_transfer;
  logic          w_unused;
  logic [CW-1:0] r_doneCnt;

  function automatic logic gateFn(input logic [1:0] m, input logic x, input logic y);
    case (m)
      2'b00:   gateFn = ~(x | y);
      2'b01:   gateFn = ~(x & y);
      2'b10:   gateFn = x ^ y;
      default: gateFn = ~(x ^ y);
    endcase
  endfunction

  // A full output that downstream refuses freezes every stage, bubbles included.
  assign w_stall    = g_stage[S].r_vld & ~out_ready;
  assign w_transfer = g_stage[S].r_vld & out_ready;
  assign in_ready   = ~w_stall;

  for (genvar s = 1; s <= S; s++) begin : g_stage
    logic         r_vld;
    logic [1:0]   r_mode;
    logic [N-1:0] r_ops;
    logic [N-2:0] r_taps;

    logic         w_srcVld;
    logic [1:0]   w_srcMode;
    logic [N-1:0] w_srcOps;
    logic [N-2:0] w_srcTaps;
    logic         w_chainIn;
    logic [N-2:0] w_nxtTaps;

    // The first stage pairs operands a and b; later stages fold in the previous tap.
    if (s == 1) begin : g_src
      assign w_srcVld  = in_valid;
      assign w_srcMode = mode;
      assign w_srcOps  = in_data;
      assign w_srcTaps = '0;
      assign w_chainIn = in_data[0];
    end else begin : g_src
      assign w_srcVld  = g_stage[s-1].r_vld;
      assign w_srcMode = g_stage[s-1].r_mode;
      assign w_srcOps  = g_stage[s-1].r_ops;
      assign w_srcTaps = g_stage[s-1].r_taps;
      assign w_chainIn = g_stage[s-1].r_taps[s-2];
    end

    always_comb begin
      w_nxtTaps      = w_srcTaps;
      w_nxtTaps[s-1] = gateFn(w_srcMode, w_srcOps[s], w_chainIn);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_mode <= 2'b00;
        r_ops  <= '0;
        r_taps <= '0;
      end else if (!w_stall) begin
        r_vld  <= w_srcVld;
        r_mode <= w_srcMode;
        r_ops  <= w_srcOps;
        r_taps <= w_nxtTaps;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_doneCnt <= '0;
    end else if (w_transfer) begin
      r_doneCnt <= r_doneCnt + CW'(1);
    end
  end

  // The last stage's operands and mode have no consumer left.
  assign w_unused = ^{g_stage[S].r_ops, g_stage[S].r_mode};

  assign taps      = g_stage[S].r_taps;
  assign result    = g_stage[S].r_taps[N-2];
  assign out_valid = g_stage[S].r_vld;
  assign done_cnt  = r_doneCnt;

endmodule

// File: tb/tb_gate_chain_pipe.sv
// Directed bench for gate_chain_pipe (N=4): a CW=8 instance plus a CW=2 instance
// sharing the same stimulus so the counter wrap can be observed.
module tb_gate_chain_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] inData;
  logic [1:0] mode;
  logic       inValid;
  logic       outReady;
  logic       inReady;
  logic [2:0] taps;
  logic       result;
  logic       outValid;
  logic [7:0] doneCnt;

  logic [1:0] doneCnt2;
  logic       unusedInReady2;
  logic [2:0] unusedTaps2;
  logic       unusedResult2;
  logic       unusedOutValid2;

  int testsRun    = 0;
  int testsFailed = 0;
  int expDone     = 0;

  gate_chain_pipe #(.N(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_data(inData), .mode(mode), .in_valid(inValid),
    .in_ready(inReady), .taps(taps), .result(result), .out_valid(outValid),
    .out_ready(outReady), .done_cnt(doneCnt)
  );

  gate_chain_pipe #(.N(4), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(inData), .mode(mode), .in_valid(inValid),
    .in_ready(unusedInReady2), .taps(unusedTaps2), .result(unusedResult2),
    .out_valid(unusedOutValid2), .out_ready(outReady), .done_cnt(doneCnt2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] d, input logic v);
    mode    = m;
    inData  = d;
    inValid = v;
  endtask

  task automatic checkDone(input string tag);
    checkOutput({tag, "_done"}, 32'(doneCnt), 32'(expDone & 255));
    checkOutput({tag, "_done_cw2"}, 32'(doneCnt2), 32'(expDone & 3));
  endtask

  task automatic checkSet(input string tag, input logic [2:0] expTaps);
    checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
    checkOutput({tag, "_taps"}, 32'(taps), 32'(expTaps));
    checkOutput({tag, "_result"}, 32'(result), 32'(expTaps[2]));
  endtask

  task automatic runSingle(input string tag, input logic [1:0] m, input logic [3:0] d,
                           input logic [2:0] expTaps);
    applyStimulus(m, d, 1'b1);
    tick;
    applyStimulus(2'b00, 4'b0000, 1'b0);
    tick;
    checkOutput({tag, "_latency"}, 32'(outValid), 32'd0);
    tick;
    checkSet(tag, expTaps);
    tick;
    expDone++;
    checkDone(tag);
    checkOutput({tag, "_drained"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    outReady = 1'b1;
    applyStimulus(2'b00, 4'b0000, 1'b0);
    #2;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_taps", 32'(taps), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_done_cnt", 32'(doneCnt), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    tick;
    rst = 1'b0;

    runSingle("nor_0000", 2'b00, 4'b0000, 3'b101);
    runSingle("nor_0001", 2'b00, 4'b0001, 3'b010);
    runSingle("nand_1111", 2'b01, 4'b1111, 3'b010);

    // Back-to-back sets, mode switching every cycle.
    applyStimulus(2'b00, 4'b1010, 1'b1);
    tick;
    applyStimulus(2'b01, 4'b0110, 1'b1);
    tick;
    applyStimulus(2'b10, 4'b1011, 1'b1);
    tick;
    checkSet("b2b_s1", 3'b010);
    applyStimulus(2'b11, 4'b0100, 1'b1);
    tick;
    checkSet("b2b_s2", 3'b101);
    applyStimulus(2'b00, 4'b0000, 1'b0);
    tick;
    checkSet("b2b_s3", 3'b100);
    tick;
    checkSet("b2b_s4", 3'b011);
    tick;
    checkOutput("b2b_drained", 32'(outValid), 32'd0);
    expDone += 4;
    checkDone("b2b");

    // Fill the pipe, then refuse the output for five cycles.
    applyStimulus(2'b10, 4'b0001, 1'b1);
    tick;
    applyStimulus(2'b00, 4'b1000, 1'b1);
    tick;
    applyStimulus(2'b11, 4'b0011, 1'b1);
    tick;
    applyStimulus(2'b01, 4'b1011, 1'b1);
    outReady = 1'b0;
    #1;
    checkOutput("stall_in_ready", 32'(inReady), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick;
      checkSet($sformatf("stall_hold%0d", i), 3'b111);
      checkOutput($sformatf("stall_in_ready%0d", i), 32'(inReady), 32'd0);
    end
    checkDone("stall_hold");
    outReady = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(inReady), 32'd1);
    tick;
    applyStimulus(2'b00, 4'b0000, 1'b0);
    checkSet("release_p2", 3'b001);
    tick;
    checkSet("release_p3", 3'b101);
    tick;
    checkSet("release_p4", 3'b010);
    tick;
    checkOutput("release_drained", 32'(outValid), 32'd0);
    expDone += 4;
    checkDone("release");

    // Asynchronous reset between edges with two sets in flight.
    applyStimulus(2'b10, 4'b0110, 1'b1);
    tick;
    applyStimulus(2'b01, 4'b0000, 1'b1);
    tick;
    applyStimulus(2'b00, 4'b0000, 1'b0);
    tick;
    checkSet("inflight_r1", 3'b001);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_out_valid", 32'(outValid), 32'd0);
    checkOutput("async_taps", 32'(taps), 32'd0);
    checkOutput("async_result", 32'(result), 32'd0);
    checkOutput("async_done_cnt", 32'(doneCnt), 32'd0);
    checkOutput("async_in_ready", 32'(inReady), 32'd1);
    expDone = 0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput($sformatf("no_stale%0d", i), 32'(outValid), 32'd0);
    end

    // Five transfers after reset walk the 2-bit counter through its wrap.
    runSingle("post_rst_nor", 2'b00, 4'b0000, 3'b101);
    runSingle("post_rst_xor", 2'b10, 4'b1011, 3'b100);
    runSingle("post_rst_xnor", 2'b11, 4'b0100, 3'b011);
    runSingle("post_rst_nand", 2'b01, 4'b0110, 3'b101);
    runSingle("post_rst_nor2", 2'b00, 4'b0001, 3'b010);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
